// File: rtl/unified_mem_arbiter.sv
// Arbitrates the single unified memory port between instruction fetch and data access.
// Data normally wins; a starvation counter forces a fetch grant after STARVE_MAX data grants.
module unified_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              flush,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {IDLE, IF_WAIT, D_WAIT, IF_DROP} state_t;

  localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

  state_t            r_state;
  logic [3:0]        r_starve_cnt;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_if_valid;
  logic              r_d_valid;

  logic w_if_elig;
  logic w_d_elig;
  logic w_grant_if;
  logic w_grant_d;

  // The valid masks stop a requester from being re-granted in the cycle its result returns.
  assign w_if_elig  = if_req && !flush && !r_if_valid;
  assign w_d_elig   = d_req && !r_d_valid;
  assign w_grant_if = w_if_elig && (!w_d_elig || (r_starve_cnt == LP_STARVE_MAX));
  assign w_grant_d  = w_d_elig && !w_grant_if;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_if_rdata   <= '0;
      r_d_rdata    <= '0;
      r_if_valid   <= 1'b0;
      r_d_valid    <= 1'b0;
    end else begin
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!if_req) r_starve_cnt <= '0;
          if (w_grant_if) begin
            r_mem_req    <= 1'b1;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= if_addr;
            r_starve_cnt <= '0;
            r_state      <= IF_WAIT;
          end else if (w_grant_d) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= d_we;
            r_mem_addr  <= d_addr;
            r_mem_wdata <= d_wdata;
            if (if_req && (r_starve_cnt != LP_STARVE_MAX))
              r_starve_cnt <= r_starve_cnt + 4'd1;
            r_state <= D_WAIT;
          end
        end
        // A flush that lands with mem_ready still completes the access but discards the word.
        IF_WAIT: begin
          if (mem_ready) begin
            r_mem_req <= 1'b0;
            r_state   <= IDLE;
            if (!flush) begin
              r_if_rdata <= mem_rdata;
              r_if_valid <= 1'b1;
            end
          end else if (flush) begin
            r_state <= IF_DROP;
          end
        end
        D_WAIT: begin
          if (mem_ready) begin
            r_mem_req <= 1'b0;
            r_d_valid <= 1'b1;
            if (!r_mem_we) r_d_rdata <= mem_rdata;
            r_state <= IDLE;
          end
        end
        IF_DROP: begin
          if (mem_ready) begin
            r_mem_req <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign if_valid  = r_if_valid;
  assign d_valid   = r_d_valid;
  assign if_stall  = if_req && !r_if_valid;
  assign d_stall   = d_req && !r_d_valid;

endmodule
